// File: rtl/ahblite_slave_mux.sv
`default_nettype none
//==============================================================================
// Module   : ahblite_slave_mux
// Brief    : AHB-Lite data-phase response mux for four peripheral ports with an
//            integrated default slave that returns a two-cycle ERROR response.
// Revision : 1.0
//==============================================================================
module ahblite_slave_mux #(
    parameter bit Port0_en = 1'b1,
    parameter bit Port1_en = 1'b1,
    parameter bit Port2_en = 1'b1,
    parameter bit Port3_en = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL_M,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P3_HSEL,
    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P3_HREADYOUT,
    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic        P3_HRESP,
    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    input  logic [31:0] P3_HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [15:0] ERR_CNT,
    output logic [31:0] ERR_ADDR
);

    localparam logic [3:0]  c_PORT_EN = {Port3_en, Port2_en, Port1_en, Port0_en};
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;
    localparam int          c_DEF     = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
    } state_t;

    logic [3:0]  w_psel;
    logic [3:0]  w_p_ready;
    logic [3:0]  w_p_resp;
    logic [31:0] w_p_rdata [4];
    logic [4:0]  w_sel_next;
    logic        w_err_next;
    logic        w_err_take;
    logic        w_unused;

    logic [4:0]  r_sel;
    logic        r_err_pend;
    state_t      r_state;
    logic        r_def_ready;
    logic        r_def_resp;
    logic [15:0] r_err_cnt;
    logic [31:0] r_err_addr;

    // Disabled legs are masked here so neither their select nor their
    // response path can ever reach the master.
    assign w_psel    = {P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL} & c_PORT_EN;
    assign w_p_ready = {P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
    assign w_p_resp  = {P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
    assign w_p_rdata[0] = P0_HRDATA;
    assign w_p_rdata[1] = P1_HRDATA;
    assign w_p_rdata[2] = P2_HRDATA;
    assign w_p_rdata[3] = P3_HRDATA;

    // Only HTRANS[1] distinguishes an active transfer from IDLE/BUSY.
    assign w_unused = HTRANS[0];

    always_comb begin
        w_sel_next = '0;
        if (w_psel[0]) begin
            w_sel_next[0] = 1'b1;
        end else if (w_psel[1]) begin
            w_sel_next[1] = 1'b1;
        end else if (w_psel[2]) begin
            w_sel_next[2] = 1'b1;
        end else if (w_psel[3]) begin
            w_sel_next[3] = 1'b1;
        end else if (HSEL_M) begin
            w_sel_next[c_DEF] = 1'b1;
        end
    end

    assign w_err_next = w_sel_next[c_DEF] & HTRANS[1];
    assign w_err_take = HREADY & w_err_next;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_sel      <= '0;
            r_err_pend <= 1'b0;
            r_err_addr <= '0;
        end else if (HREADY) begin
            r_sel      <= w_sel_next;
            r_err_pend <= w_err_next;
            if (w_err_next) begin
                r_err_addr <= HADDR;
            end
        end
    end

    // Default slave: ERR1 stalls with HRESP high, ERR2 completes the error.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= S_IDLE;
            r_def_ready <= 1'b1;
            r_def_resp  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_err_take) begin
                        r_state     <= S_ERR1;
                        r_def_ready <= 1'b0;
                        r_def_resp  <= 1'b1;
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_def_ready <= 1'b1;
                    r_def_resp  <= 1'b1;
                    if (r_err_cnt != c_CNT_MAX) begin
                        r_err_cnt <= r_err_cnt + 16'd1;
                    end
                end
                S_ERR2: begin
                    if (w_err_take) begin
                        r_state     <= S_ERR1;
                        r_def_ready <= 1'b0;
                        r_def_resp  <= 1'b1;
                    end else begin
                        r_state     <= S_IDLE;
                        r_def_ready <= 1'b1;
                        r_def_resp  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_def_ready <= 1'b1;
                    r_def_resp  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_sel[i] && c_PORT_EN[i]) begin
                HREADYOUT = w_p_ready[i];
                HRESP     = w_p_resp[i];
                HRDATA    = w_p_rdata[i];
            end
        end
        if (r_sel[c_DEF] && r_err_pend) begin
            HREADYOUT = r_def_ready;
            HRESP     = r_def_resp;
        end
    end

    assign ERR_CNT  = r_err_cnt;
    assign ERR_ADDR = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_ahblite_slave_mux.sv
`default_nettype none
//==============================================================================
// Module   : tb_ahblite_slave_mux
// Brief    : Scoreboard bench for ahblite_slave_mux (port 3 disabled).
// Revision : 1.0
//==============================================================================
module tb_ahblite_slave_mux;

    localparam logic [3:0] c_EN = 4'b0111;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel_m;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic [3:0]  p_hsel;
    logic [3:0]  p_ready;
    logic [3:0]  p_resp;
    logic [31:0] p_rdata [4];
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [15:0] err_cnt;
    logic [31:0] err_addr;

    always #5 clk = ~clk;
    assign hready = hreadyout;

    ahblite_slave_mux #(
        .Port0_en(1'b1), .Port1_en(1'b1), .Port2_en(1'b1), .Port3_en(1'b0)
    ) dut (
        .HCLK(clk), .HRESET(rst), .HSEL_M(hsel_m), .HADDR(haddr), .HTRANS(htrans),
        .HREADY(hready),
        .P0_HSEL(p_hsel[0]), .P1_HSEL(p_hsel[1]), .P2_HSEL(p_hsel[2]), .P3_HSEL(p_hsel[3]),
        .P0_HREADYOUT(p_ready[0]), .P1_HREADYOUT(p_ready[1]),
        .P2_HREADYOUT(p_ready[2]), .P3_HREADYOUT(p_ready[3]),
        .P0_HRESP(p_resp[0]), .P1_HRESP(p_resp[1]), .P2_HRESP(p_resp[2]), .P3_HRESP(p_resp[3]),
        .P0_HRDATA(p_rdata[0]), .P1_HRDATA(p_rdata[1]),
        .P2_HRDATA(p_rdata[2]), .P3_HRDATA(p_rdata[3]),
        .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
        .ERR_CNT(err_cnt), .ERR_ADDR(err_addr)
    );

    typedef enum logic [1:0] {K_OKAY, K_PORT, K_ERR} kind_t;

    typedef struct {
        logic        hsel_m;
        logic [3:0]  psel;
        logic [1:0]  htrans;
        logic [31:0] addr;
        int          wt;
        logic [31:0] data;
        logic        resp;
    } req_t;

    typedef struct {
        kind_t       kind;
        int          port;
        int          wt;
        logic [31:0] data;
        logic        resp;
        logic [15:0] cnt;
        logic [31:0] addr;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          cur_cycle;
    int          mon_cycle;
    int          m_cnt;
    logic [31:0] m_addr;
    int          n_chk;
    int          n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: classify a transfer and track the error statistics it implies.
    function automatic exp_t predict(input req_t r);
        exp_t e;
        int   pick = -1;
        for (int i = 3; i >= 0; i--) if (r.psel[i] && c_EN[i]) pick = i;
        e.port = pick;
        e.wt   = r.wt;
        e.data = r.data;
        e.resp = r.resp;
        if (pick >= 0) begin
            e.kind = K_PORT;
        end else if (r.hsel_m && (r.htrans == 2'd2 || r.htrans == 2'd3)) begin
            e.kind = K_ERR;
            if (m_cnt < 65535) m_cnt++;
            m_addr = r.addr;
        end else begin
            e.kind = K_OKAY;
        end
        e.cnt  = 16'(m_cnt);
        e.addr = m_addr;
        return e;
    endfunction

    function automatic bit cur_done();
        case (cur.kind)
            K_PORT:  return cur_cycle >= cur.wt;
            K_ERR:   return cur_cycle >= 1;
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive_ports();
        bit rdy;
        for (int i = 0; i < 4; i++) begin
            if (cur.kind == K_PORT && cur.port == i) begin
                rdy        = (cur_cycle >= cur.wt);
                p_ready[i] = rdy;
                p_resp[i]  = rdy ? cur.resp : 1'b0;
                p_rdata[i] = rdy ? cur.data : $urandom;
            end else begin
                p_ready[i] = 1'($urandom);
                p_resp[i]  = 1'($urandom);
                p_rdata[i] = $urandom;
            end
        end
    endtask

    // Presents one address phase while finishing the current data phase.
    task automatic issue(input req_t r);
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            hsel_m = r.hsel_m;
            p_hsel = r.psel;
            htrans = r.htrans;
            haddr  = r.addr;
            drive_ports();
            done = cur_done();
            @(posedge clk);
            if (!done) cur_cycle++;
        end
        cur       = predict(r);
        cur_cycle = 0;
        q.push_back(cur);
    endtask

    function automatic req_t mk(input logic hs, input logic [3:0] ps, input logic [1:0] ht,
                                input logic [31:0] a, input int wt, input logic [31:0] d);
        req_t r;
        r.hsel_m = hs; r.psel = ps; r.htrans = ht; r.addr = a;
        r.wt = wt; r.data = d; r.resp = 1'b0;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.hsel_m = ($urandom_range(0, 7) != 0);
        r.psel   = (r.hsel_m && $urandom_range(0, 2) != 0) ? 4'($urandom) : 4'b0000;
        r.htrans = 2'($urandom);
        r.addr   = $urandom;
        r.wt     = $urandom_range(0, 2);
        r.data   = $urandom;
        r.resp   = ($urandom_range(0, 3) == 0);
        return r;
    endfunction

    // Monitor: compares every cycle of the oldest outstanding data phase.
    initial begin
        exp_t e;
        bit   exp_rdy;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && q.size() > 0) begin
                e = q[0];
                case (e.kind)
                    K_PORT: begin
                        exp_rdy = (mon_cycle >= e.wt);
                        check("port_ready", 32'(hreadyout), 32'(exp_rdy));
                        if (exp_rdy) begin
                            check("port_resp", 32'(hresp), 32'(e.resp));
                            check("port_rdata", hrdata, e.data);
                        end
                    end
                    K_ERR: begin
                        exp_rdy = (mon_cycle >= 1);
                        check("err_ready", 32'(hreadyout), 32'(exp_rdy));
                        check("err_resp", 32'(hresp), 32'd1);
                        check("err_rdata", hrdata, 32'd0);
                    end
                    default: begin
                        exp_rdy = 1'b1;
                        check("okay_ready", 32'(hreadyout), 32'd1);
                        check("okay_resp", 32'(hresp), 32'd0);
                        check("okay_rdata", hrdata, 32'd0);
                    end
                endcase
                if (exp_rdy) begin
                    check("err_cnt", 32'(err_cnt), 32'(e.cnt));
                    check("err_addr", err_addr, e.addr);
                    void'(q.pop_front());
                    mon_cycle = 0;
                end else begin
                    mon_cycle++;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hreadyout"}, 32'(hreadyout), 32'd1);
        check({tag, "_hresp"}, 32'(hresp), 32'd0);
        check({tag, "_hrdata"}, hrdata, 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_err_addr"}, err_addr, 32'd0);
    endtask

    localparam logic [31:0] c_IDLE_A = 32'h0000_0000;

    initial begin
        n_chk = 0; n_pass = 0; mon_cycle = 0; cur_cycle = 0;
        m_cnt = 0; m_addr = '0;
        cur.kind = K_OKAY; cur.port = -1; cur.wt = 0;
        rst = 1'b1; hsel_m = 1'b0; haddr = '0; htrans = 2'd0; p_hsel = '0;
        drive_ports();
        @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of ERR1.
        issue(mk(1'b1, 4'b0000, 2'd2, 32'hC000_0000, 0, 0));
        @(negedge clk);
        #1 check("pre_reset_err1_ready", 32'(hreadyout), 32'd0);
        q.delete();
        rst = 1'b1;
        hsel_m = 1'b0; htrans = 2'd0; p_hsel = '0;
        #1 check_reset_outputs("midreset");
        cur.kind = K_OKAY; cur_cycle = 0; mon_cycle = 0;
        m_cnt = 0; m_addr = '0;
        @(negedge clk);
        rst = 1'b0;

        // Port 1 with two wait states; following address must wait for release.
        issue(mk(1'b1, 4'b0010, 2'd2, 32'hA001_0010, 2, 32'h1234_5678));
        issue(mk(1'b1, 4'b0100, 2'd2, 32'hA002_0000, 1, 32'hCAFE_F00D));
        // Unmapped via disabled port 3, then via no select at all.
        issue(mk(1'b1, 4'b1000, 2'd2, 32'hB000_0004, 0, 0));
        issue(mk(1'b1, 4'b0000, 2'd0, c_IDLE_A, 0, 0));
        // Back-to-back unmapped NONSEQ/SEQ.
        issue(mk(1'b1, 4'b0000, 2'd2, 32'hB000_0000, 0, 0));
        issue(mk(1'b1, 4'b0000, 2'd3, 32'hB000_0008, 0, 0));
        // IDLE and BUSY to unmapped addresses must stay silent.
        issue(mk(1'b1, 4'b0000, 2'd0, 32'hDEAD_0000, 0, 0));
        issue(mk(1'b1, 4'b0000, 2'd1, 32'hDEAD_0004, 0, 0));
        // Illegal multi-select: P0 wins.
        issue(mk(1'b1, 4'b0011, 2'd2, 32'h0000_1000, 1, 32'h0BAD_BEEF));
        issue(mk(1'b0, 4'b0000, 2'd0, c_IDLE_A, 0, 0));

        // Saturation: preload the counter, then three more errors.
        repeat (2) @(negedge clk);
        force dut.r_err_cnt = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.r_err_cnt;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) issue(mk(1'b1, 4'b0000, 2'd2, 32'hB100_0000 + 32'(i * 4), 0, 0));
        issue(mk(1'b0, 4'b0000, 2'd0, c_IDLE_A, 0, 0));

        for (int i = 0; i < 300; i++) issue(rnd_req());
        issue(mk(1'b0, 4'b0000, 2'd0, c_IDLE_A, 0, 0));
        repeat (4) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
